// File: rtl/prio_arb_enc.sv
// Registered priority arbiter: snapshots a request vector and issues one grant per
// acknowledge, in fixed (highest index first) or round-robin order chosen per batch.
module prio_arb_enc #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         gnt_ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic [W:0]   pend_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [N-1:0] snap;
  logic         mode_q;
  logic [W-1:0] ptr;

  logic [W-1:0] first_win;
  logic [N-1:0] snap_nxt;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] next_win;

  function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) r = W'(i);
    return r;
  endfunction

  // First set bit at or above p, wrapping from N-1 back to 0.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] v, input logic [W-1:0] p);
    logic [W-1:0] r;
    logic         found;
    int           j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(p) + k) % N;
      if (!found && v[j]) begin
        r     = W'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [W:0] popcnt(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      c = c + (W+1)'(v[i]);
    return c;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    return N'(1) << idx;
  endfunction

  always_comb begin
    first_win = mode ? pick_rr(req, ptr) : pick_fixed(req);
    snap_nxt  = snap & ~gnt_onehot;
    ptr_nxt   = (gnt_idx == W'(N-1)) ? '0 : gnt_idx + 1'b1;
    next_win  = mode_q ? pick_rr(snap_nxt, ptr_nxt) : pick_fixed(snap_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      mode_q     <= 1'b0;
      ptr        <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      pend_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            snap       <= req;
            mode_q     <= mode;
            gnt_valid  <= 1'b1;
            gnt_idx    <= first_win;
            gnt_onehot <= onehot(first_win);
            pend_cnt   <= popcnt(req);
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_ack) begin
            snap <= snap_nxt;
            if (mode_q) ptr <= ptr_nxt;
            if (|snap_nxt) begin
              gnt_idx    <= next_win;
              gnt_onehot <= onehot(next_win);
              pend_cnt   <= pend_cnt - 1'b1;
            end else begin
              gnt_valid  <= 1'b0;
              gnt_idx    <= '0;
              gnt_onehot <= '0;
              pend_cnt   <= '0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arb_enc.sv
// Bench for prio_arb_enc: directed scenarios with literal expectations plus random
// traffic checked every cycle against a grant-order queue model.
module tb_prio_arb_enc;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n, mode, gnt_ack;
  logic [N-1:0] req;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic [W:0]   pend_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  prio_arb_enc #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .gnt_ack(gnt_ack),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at capture the whole service order is known, so keep it as a queue.
  int m_q[$];
  int m_ptr   = 0;
  bit m_mode  = 0;
  bit m_armed = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_ptr   = 0;
      m_armed = 1;
    end else if (m_q.size() == 0) begin
      if (req != '0) begin
        m_mode = mode;
        if (!mode) begin
          for (int i = N - 1; i >= 0; i--) if (req[i]) m_q.push_back(i);
        end else begin
          for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) m_q.push_back((m_ptr + k) % N);
        end
      end
    end else if (gnt_ack) begin
      int w;
      w = m_q.pop_front();
      if (m_mode) m_ptr = (w + 1) % N;
    end
    #2;
    if (m_armed) begin
      chk("m_valid",  64'(gnt_valid),  64'(m_q.size() != 0));
      chk("m_idx",    64'(gnt_idx),    (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
      chk("m_onehot", 64'(gnt_onehot), (m_q.size() != 0) ? (64'd1 << m_q[0]) : 64'd0);
      chk("m_pend",   64'(pend_cnt),   64'(m_q.size()));
    end
  end

  task automatic drive(input logic r_n, input logic [N-1:0] r, input logic m, input logic a);
    @(negedge clk);
    rst_n = r_n; req = r; mode = m; gnt_ack = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input int idx, input int pend);
    chk({name, "_valid"},  64'(gnt_valid),  64'(v));
    chk({name, "_idx"},    64'(gnt_idx),    64'(idx));
    chk({name, "_onehot"}, 64'(gnt_onehot), v ? (64'd1 << idx) : 64'd0);
    chk({name, "_pend"},   64'(pend_cnt),   64'(pend));
  endtask

  initial begin
    rst_n = 1'b0; req = 8'hFF; mode = 1'b0; gnt_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("reset", 0, 0, 0);
    end
    drive(1, 8'h00, 0, 0); tick(); expect_out("idle", 0, 0, 0);

    // Fixed drain
    drive(1, 8'b0010_0110, 0, 1); tick(); expect_out("fix0", 1, 5, 3);
    chk("fix0_oh_lit", 64'(gnt_onehot), 64'h20);
    drive(1, 8'h00, 0, 1); tick(); expect_out("fix1", 1, 2, 2);
    chk("fix1_oh_lit", 64'(gnt_onehot), 64'h04);
    tick(); expect_out("fix2", 1, 1, 1);
    chk("fix2_oh_lit", 64'(gnt_onehot), 64'h02);
    tick(); expect_out("fix3", 0, 0, 0);

    // Hold while ack low, req toggling
    drive(1, 8'h40, 0, 0); tick(); expect_out("hold_cap", 1, 6, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, (i % 2 == 0) ? 8'hFF : 8'h00, i[0], 0); tick();
      expect_out("hold", 1, 6, 1);
    end
    drive(1, 8'h00, 0, 1); tick(); expect_out("hold_end", 0, 0, 0);

    // Round-robin wrap; the third batch pins ptr=5
    drive(1, 8'h12, 1, 1); tick(); expect_out("rr0", 1, 1, 2);
    drive(1, 8'h00, 1, 1); tick(); expect_out("rr1", 1, 4, 1);
    tick(); expect_out("rr2", 0, 0, 0);
    drive(1, 8'h92, 1, 1); tick(); expect_out("rr3", 1, 7, 3);
    drive(1, 8'h00, 1, 1); tick(); expect_out("rr4", 1, 1, 2);
    tick(); expect_out("rr5", 1, 4, 1);
    tick(); expect_out("rr6", 0, 0, 0);
    drive(1, 8'h21, 1, 1); tick(); expect_out("rr_ptr5", 1, 5, 2);
    drive(1, 8'h00, 0, 1); tick(); expect_out("rr_ptr5b", 1, 0, 1);
    tick(); expect_out("rr_end", 0, 0, 0);

    // Mode latched at capture
    drive(1, 8'h0F, 0, 1); tick(); expect_out("ml0", 1, 3, 4);
    drive(1, 8'h00, 1, 1); tick(); expect_out("ml1", 1, 2, 3);
    tick(); expect_out("ml2", 1, 1, 2);
    tick(); expect_out("ml3", 1, 0, 1);
    tick(); expect_out("ml4", 0, 0, 0);

    // Mid-batch reset discards the rest
    drive(1, 8'h0F, 0, 1); tick(); expect_out("mr0", 1, 3, 4);
    drive(1, 8'h00, 0, 1); tick(); expect_out("mr1", 1, 2, 3);
    drive(0, 8'h00, 0, 1); tick(); expect_out("mr_rst", 0, 0, 0);
    drive(1, 8'h00, 0, 1); tick(); expect_out("mr_after", 0, 0, 0);

    // Latency and single bubble
    drive(1, 8'h08, 0, 1); tick(); expect_out("lat0", 1, 3, 1);
    tick(); expect_out("bubble", 0, 0, 0);
    tick(); expect_out("recap", 1, 3, 1);
    drive(1, 8'h00, 0, 1); tick(); expect_out("lat_end", 0, 0, 0);

    // Random traffic; the model process checks every cycle
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      drive(($urandom_range(0, 59) != 0), r, 1'($urandom), ($urandom_range(0, 9) < 6));
    end
    drive(1, 8'h00, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
